// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state type and default WS2812 timing constants
package ws2812_pkg;
  localparam int BIT_CYCLES_DEF = 15;
  localparam int T1H_CYCLES_DEF = 10;
  localparam int T0H_CYCLES_DEF = 5;
  localparam int PIXEL_BITS_DEF = 24;
  typedef enum logic [1:0] {IDLE, LOADED, SEND, DONE} state_e;
endpackage

// File: rtl/ws2812_if.sv
// ws2812_if: pixel load/transmit controls and serial outputs; WS2812_UNDERRUN_FLAG_EN adds underrun
interface ws2812_if;
  logic       load_sreg;
  logic       transmit_pixel;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       data_out;
  logic       busy;
`ifdef WS2812_UNDERRUN_FLAG_EN
  logic       underrun;
  modport master (output load_sreg, transmit_pixel, red, green, blue, input data_out, busy, underrun);
  modport slave (input load_sreg, transmit_pixel, red, green, blue, output data_out, busy, underrun);
`else
  modport master (output load_sreg, transmit_pixel, red, green, blue, input data_out, busy);
  modport slave (input load_sreg, transmit_pixel, red, green, blue, output data_out, busy);
`endif
endinterface

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: per-bit cycle counter with high-phase and last-cycle decode
module ws2812_bit_timer #(
  parameter int BIT_CYCLES = 15,
  parameter int T1H_CYCLES = 10,
  parameter int T0H_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  input  logic bit_i,
  output logic high_o,
  output logic last_o
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T1H = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] T0H = CW'(T0H_CYCLES);
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  assign last_o = cycle_cnt_q == LAST;
  assign high_o = cycle_cnt_q < (bit_i ? T1H : T0H);
  // count while running, wrap at the end of each bit, clear on request
  always_comb begin
    cycle_cnt_d = clr_i ? '0 : run_i ? (last_o ? '0 : cycle_cnt_q + 1'b1) : cycle_cnt_q;
  end
  // cycle counter register
  always_ff @(posedge clk) begin
    if (rst) cycle_cnt_q <= '0;
    else     cycle_cnt_q <= cycle_cnt_d;
  end
endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises one GRB pixel onto a WS2812 line; WS2812_UNDERRUN_FLAG_EN adds a sticky underrun flag
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int T1H_CYCLES = T1H_CYCLES_DEF,
  parameter int T0H_CYCLES = T0H_CYCLES_DEF,
  parameter int PIXEL_BITS = PIXEL_BITS_DEF
) (
  input logic clk,
  input logic rst,
  ws2812_if.slave bus
);
  localparam int BW = $clog2(PIXEL_BITS);
  state_e state_q, state_d;
  logic [PIXEL_BITS-1:0] sreg_q, sreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic data_out_q, data_out_d;
  logic tmr_clr, tmr_run, tmr_high, tmr_last, last_bit;
  assign last_bit = bit_cnt_q == BW'(PIXEL_BITS - 1);
  assign bus.data_out = data_out_q;
  assign bus.busy = state_q == SEND;
  ws2812_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .T0H_CYCLES(T0H_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .run_i (tmr_run),
    .bit_i (sreg_q[PIXEL_BITS-1]),
    .high_o(tmr_high),
    .last_o(tmr_last)
  );
  // next state: load beats everything; SEND emits the MSB waveform and shifts at bit end
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    data_out_d = 1'b0;
    tmr_clr    = 1'b0;
    tmr_run    = 1'b0;
    if (bus.load_sreg) begin
      state_d   = LOADED;
      sreg_d    = PIXEL_BITS'({bus.green, bus.red, bus.blue});
      bit_cnt_d = '0;
      tmr_clr   = 1'b1;
    end else begin
      case (state_q)
        LOADED: state_d = bus.transmit_pixel ? SEND : LOADED;
        SEND: begin
          if (!bus.transmit_pixel) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tmr_clr   = 1'b1;
          end else begin
            data_out_d = tmr_high;
            tmr_run    = 1'b1;
            if (tmr_last) begin
              sreg_d    = sreg_q << 1;
              state_d   = last_bit ? DONE : SEND;
              bit_cnt_d = last_bit ? bit_cnt_q : bit_cnt_q + 1'b1;
            end
          end
        end
        DONE: state_d = bus.transmit_pixel ? DONE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // state, shift register, bit counter and registered serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
    end
  end
`ifdef WS2812_UNDERRUN_FLAG_EN
  logic underrun_q, underrun_d;
  assign underrun_d = underrun_q | (state_q == SEND && (bus.load_sreg || !bus.transmit_pixel));
  assign bus.underrun = underrun_q;
  // sticky flag: a pixel was cut short by an abort or a reload
  always_ff @(posedge clk) begin
    if (rst) underrun_q <= 1'b0;
    else     underrun_q <= underrun_d;
  end
`endif
endmodule
